// File: rtl/pic_service_controller.sv
// Interrupt service sequencer for an 8-level PIC: priority resolution against
// the In-Service Register, two-pulse INTA handshake, vector return and EOI handling.
module pic_service_controller #(
    parameter int SPURIOUS_LEVEL = 7,
    parameter int ACK_TIMEOUT    = 16,
    parameter int TMO_W          = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] irq_req,
    input  logic [7:0] imr,
    input  logic       inta_strobe,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    input  logic       aeoi_en,
    input  logic       aeoi_rotate,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] irr_clear,
    output logic [7:0] isr,
    output logic [2:0] lowest_prio,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       ack_abort
);
    typedef enum logic [0:0] {ST_IDLE, ST_WAIT_ACK2} state_t;

    localparam logic [2:0]       SPUR_LVL = 3'(SPURIOUS_LEVEL);
    localparam bit               TMO_EN   = (ACK_TIMEOUT > 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t           r_state, w_state_next;
    logic [2:0]       r_level, w_level_next;
    logic             r_spur, w_spur_next;
    logic [TMO_W-1:0] r_cnt, w_cnt_next;
    logic             r_int, w_int_next;
    logic [7:0]       r_irr_clear, w_irr_clear_next;
    logic [7:0]       r_isr, w_isr_next;
    logic [2:0]       r_lowest, w_lowest_next;
    logic             r_vec_valid, w_vec_valid_next;
    logic [7:0]       r_vec_data, w_vec_data_next;
    logic             r_ack_abort, w_ack_abort_next;

    logic [2:0] w_lvl_of_rank [8];
    logic [7:0] w_req_rank, w_isr_rank;
    logic [2:0] w_cand_rank, w_isr_best_rank, w_cand_lvl, w_isr_lvl;
    logic       w_cand_any, w_isr_any, w_cand_valid;
    logic [7:0] w_isr_set, w_isr_clr;

    // Index 0 of the rank vectors is the level just above lowest_prio.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rank
            assign w_lvl_of_rank[gi] = r_lowest + 3'(gi + 1);
            assign w_req_rank[gi]    = irq_req[w_lvl_of_rank[gi]] & ~imr[w_lvl_of_rank[gi]];
            assign w_isr_rank[gi]    = r_isr[w_lvl_of_rank[gi]];
        end
    endgenerate

    always_comb begin
        w_cand_rank     = 3'd0;
        w_cand_any      = 1'b0;
        w_isr_best_rank = 3'd0;
        w_isr_any       = 1'b0;
        for (int r = 7; r >= 0; r--) begin
            if (w_req_rank[r]) begin
                w_cand_rank = 3'(r);
                w_cand_any  = 1'b1;
            end
            if (w_isr_rank[r]) begin
                w_isr_best_rank = 3'(r);
                w_isr_any       = 1'b1;
            end
        end
    end

    assign w_cand_lvl   = w_lvl_of_rank[w_cand_rank];
    assign w_isr_lvl    = w_lvl_of_rank[w_isr_best_rank];
    assign w_cand_valid = w_cand_any && (!w_isr_any || (w_cand_rank < w_isr_best_rank));

    always_comb begin
        w_state_next     = r_state;
        w_level_next     = r_level;
        w_spur_next      = r_spur;
        w_cnt_next       = r_cnt;
        w_int_next       = 1'b0;
        w_irr_clear_next = 8'h00;
        w_vec_valid_next = 1'b0;
        w_vec_data_next  = r_vec_data;
        w_ack_abort_next = 1'b0;
        w_lowest_next    = r_lowest;
        w_isr_set        = 8'h00;
        w_isr_clr        = 8'h00;

        if (eoi_valid) begin
            if (eoi_specific) begin
                w_isr_clr[eoi_level] = 1'b1;
                if (eoi_rotate) w_lowest_next = eoi_level;
            end else if (w_isr_any) begin
                w_isr_clr[w_isr_lvl] = 1'b1;
                if (eoi_rotate) w_lowest_next = w_isr_lvl;
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_int_next = w_cand_valid;
                if (inta_strobe) begin
                    w_int_next   = 1'b0;
                    w_state_next = ST_WAIT_ACK2;
                    w_cnt_next   = '0;
                    if (w_cand_valid) begin
                        w_isr_set[w_cand_lvl]        = 1'b1;
                        w_irr_clear_next[w_cand_lvl] = 1'b1;
                        w_level_next                 = w_cand_lvl;
                        w_spur_next                  = 1'b0;
                    end else begin
                        w_level_next = SPUR_LVL;
                        w_spur_next  = 1'b1;
                    end
                end
            end
            ST_WAIT_ACK2: begin
                w_cnt_next = r_cnt + TMO_W'(1);
                if (inta_strobe) begin
                    w_vec_valid_next = 1'b1;
                    w_vec_data_next  = {vector_base, r_level};
                    w_state_next     = ST_IDLE;
                    // AEOI rotation is applied after EOI rotation so it wins.
                    if (aeoi_en && !r_spur) begin
                        w_isr_clr[r_level] = 1'b1;
                        if (aeoi_rotate) w_lowest_next = r_level;
                    end
                end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
                    w_ack_abort_next = 1'b1;
                    w_state_next     = ST_IDLE;
                    if (!r_spur) w_isr_clr[r_level] = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        w_isr_next = (r_isr & ~w_isr_clr) | w_isr_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_level     <= 3'd0;
            r_spur      <= 1'b0;
            r_cnt       <= '0;
            r_int       <= 1'b0;
            r_irr_clear <= 8'h00;
            r_isr       <= 8'h00;
            r_lowest    <= 3'd7;
            r_vec_valid <= 1'b0;
            r_vec_data  <= 8'h00;
            r_ack_abort <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_level     <= w_level_next;
            r_spur      <= w_spur_next;
            r_cnt       <= w_cnt_next;
            r_int       <= w_int_next;
            r_irr_clear <= w_irr_clear_next;
            r_isr       <= w_isr_next;
            r_lowest    <= w_lowest_next;
            r_vec_valid <= w_vec_valid_next;
            r_vec_data  <= w_vec_data_next;
            r_ack_abort <= w_ack_abort_next;
        end
    end

    assign int_out     = r_int;
    assign irr_clear   = r_irr_clear;
    assign isr         = r_isr;
    assign lowest_prio = r_lowest;
    assign vec_valid   = r_vec_valid;
    assign vec_data    = r_vec_data;
    assign ack_abort   = r_ack_abort;
endmodule

// File: tb/tb_pic_service_controller.sv
// Bench for pic_service_controller: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural priority/ISR model.
module tb_pic_service_controller;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_req, imr;
    logic       inta_strobe, eoi_valid, eoi_specific, eoi_rotate;
    logic [2:0] eoi_level;
    logic       aeoi_en, aeoi_rotate;
    logic [4:0] vector_base;
    logic       int_out, vec_valid, ack_abort;
    logic [7:0] irr_clear, isr, vec_data;
    logic [2:0] lowest_prio;

    int n_vec = 0;
    int n_err = 0;

    pic_service_controller dut (
        .clk(clk), .reset_n(reset_n), .irq_req(irq_req), .imr(imr),
        .inta_strobe(inta_strobe), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
        .eoi_rotate(eoi_rotate), .eoi_level(eoi_level), .aeoi_en(aeoi_en),
        .aeoi_rotate(aeoi_rotate), .vector_base(vector_base), .int_out(int_out),
        .irr_clear(irr_clear), .isr(isr), .lowest_prio(lowest_prio),
        .vec_valid(vec_valid), .vec_data(vec_data), .ack_abort(ack_abort)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] m_isr, m_irr_clear, m_vec_data;
    int         m_lowest, m_level, m_cnt;
    bit         m_wait, m_spur, m_int, m_vec_valid, m_abort;

    function automatic int rank(input int lvl);
        return (lvl - m_lowest - 1 + 16) % 8;
    endfunction

    task automatic model_reset();
        m_isr = 8'h00; m_irr_clear = 8'h00; m_vec_data = 8'h00;
        m_lowest = 7; m_level = 0; m_cnt = 0;
        m_wait = 0; m_spur = 0; m_int = 0; m_vec_valid = 0; m_abort = 0;
    endtask

    task automatic model_step();
        int cand = -1, cand_r = 8, best = -1, best_r = 8, rot = -1;
        logic [7:0] clr = 8'h00, set = 8'h00;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            if (irq_req[i] && !imr[i] && rank(i) < cand_r) begin cand_r = rank(i); cand = i; end
            if (m_isr[i] && rank(i) < best_r) begin best_r = rank(i); best = i; end
        end
        ok = (cand >= 0) && (cand_r < best_r);
        if (eoi_valid) begin
            if (eoi_specific) begin
                clr[eoi_level] = 1'b1;
                if (eoi_rotate) rot = int'(eoi_level);
            end else if (best >= 0) begin
                clr[best] = 1'b1;
                if (eoi_rotate) rot = best;
            end
        end
        m_irr_clear = 8'h00; m_vec_valid = 0; m_abort = 0; m_int = 0;
        if (!m_wait) begin
            m_int = ok;
            if (inta_strobe) begin
                m_int = 0; m_wait = 1; m_cnt = 0;
                if (ok) begin
                    set[cand] = 1'b1; m_irr_clear[cand] = 1'b1; m_level = cand; m_spur = 0;
                end else begin
                    m_level = 7; m_spur = 1;
                end
            end
        end else begin
            if (inta_strobe) begin
                m_vec_valid = 1; m_vec_data = {vector_base, 3'(m_level)}; m_wait = 0;
                if (aeoi_en && !m_spur) begin
                    clr[m_level] = 1'b1;
                    if (aeoi_rotate) rot = m_level;
                end
            end else if (m_cnt == 15) begin
                m_abort = 1; m_wait = 0;
                if (!m_spur) clr[m_level] = 1'b1;
            end
            m_cnt = m_cnt + 1;
        end
        m_isr = (m_isr & ~clr) | set;
        if (rot >= 0) m_lowest = rot;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_inta();
        inta_strobe = 1'b1; tick(); inta_strobe = 1'b0;
    endtask

    task automatic send_eoi(input bit spec, input bit rot, input logic [2:0] lvl);
        eoi_valid = 1'b1; eoi_specific = spec; eoi_rotate = rot; eoi_level = lvl;
        tick();
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
    endtask

    task automatic test_reset();
        irq_req = 8'h00; imr = 8'h00; inta_strobe = 0; eoi_valid = 0; eoi_specific = 0;
        eoi_rotate = 0; eoi_level = 0; aeoi_en = 0; aeoi_rotate = 0; vector_base = 5'h08;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL reset_int got=%b exp=0", int_out); end
        n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL reset_isr got=%h exp=00", isr); end
        n_vec++; if (lowest_prio !== 3'd7) begin n_err++; $display("FAIL reset_lowest got=%0d exp=7", lowest_prio); end
        n_vec++; if ({vec_valid, vec_data, ack_abort, irr_clear} !== 18'h0) begin
            n_err++; $display("FAIL reset_outs vv=%b vd=%h ab=%b irrc=%h exp=0", vec_valid, vec_data, ack_abort, irr_clear);
        end
        reset_n = 1'b1;
        $display("reset: isr=%h lowest=%0d", isr, lowest_prio);
    endtask

    task automatic test_basic_ack();
        irq_req = 8'h24;
        tick();
        n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL basic_int got=%b exp=1", int_out); end
        pulse_inta();
        n_vec++; if (irr_clear !== 8'h04) begin n_err++; $display("FAIL basic_irrc got=%h exp=04", irr_clear); end
        n_vec++; if (isr !== 8'h04) begin n_err++; $display("FAIL basic_isr got=%h exp=04", isr); end
        irq_req = 8'h20;
        tick();
        pulse_inta();
        n_vec++; if (vec_valid !== 1'b1 || vec_data !== 8'h42) begin
            n_err++; $display("FAIL basic_vec got vv=%b vd=%h exp vv=1 vd=42", vec_valid, vec_data);
        end
        tick();
        n_vec++; if (vec_valid !== 1'b0) begin n_err++; $display("FAIL basic_vv_pulse got=%b exp=0", vec_valid); end
        $display("basic ack: vec=%h isr=%h", vec_data, isr);
    endtask

    task automatic test_nesting();
        irq_req = 8'h08;
        tick();
        n_vec++; if (int_out !== 1'b0) begin n_err++; $display("FAIL nest_block got=%b exp=0", int_out); end
        irq_req = 8'h01;
        tick();
        n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL nest_int got=%b exp=1", int_out); end
        pulse_inta();
        n_vec++; if (isr !== 8'h05) begin n_err++; $display("FAIL nest_isr got=%h exp=05", isr); end
        irq_req = 8'h00;
        pulse_inta();
        n_vec++; if (vec_data !== 8'h40) begin n_err++; $display("FAIL nest_vec got=%h exp=40", vec_data); end
        send_eoi(1'b0, 1'b0, 3'd0);
        n_vec++; if (isr !== 8'h04) begin n_err++; $display("FAIL nest_eoi got=%h exp=04", isr); end
        $display("nesting: isr=%h", isr);
    endtask

    task automatic test_rotation();
        send_eoi(1'b1, 1'b1, 3'd3);
        n_vec++; if (lowest_prio !== 3'd3 || isr !== 8'h04) begin
            n_err++; $display("FAIL rot_eoi got lp=%0d isr=%h exp lp=3 isr=04", lowest_prio, isr);
        end
        irq_req = 8'h11;
        tick();
        pulse_inta();
        n_vec++; if (irr_clear !== 8'h10 || isr !== 8'h14) begin
            n_err++; $display("FAIL rot_ack got irrc=%h isr=%h exp irrc=10 isr=14", irr_clear, isr);
        end
        irq_req = 8'h01;
        tick();
        pulse_inta();
        n_vec++; if (vec_data !== 8'h44) begin n_err++; $display("FAIL rot_vec got=%h exp=44", vec_data); end
        send_eoi(1'b0, 1'b0, 3'd0);
        send_eoi(1'b0, 1'b0, 3'd0);
        n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL rot_clean got=%h exp=00", isr); end
        $display("rotation: vec=%h lowest=%0d", vec_data, lowest_prio);
    endtask

    task automatic test_spurious();
        tick();
        n_vec++; if (int_out !== 1'b1) begin n_err++; $display("FAIL spur_int got=%b exp=1", int_out); end
        irq_req = 8'h00;
        pulse_inta();
        n_vec++; if (irr_clear !== 8'h00 || isr !== 8'h00) begin
            n_err++; $display("FAIL spur_ack got irrc=%h isr=%h exp 00/00", irr_clear, isr);
        end
        tick();
        pulse_inta();
        n_vec++; if (vec_valid !== 1'b1 || vec_data !== 8'h47) begin
            n_err++; $display("FAIL spur_vec got vv=%b vd=%h exp vv=1 vd=47", vec_valid, vec_data);
        end
        $display("spurious: vec=%h", vec_data);
    endtask

    task automatic test_aeoi();
        aeoi_en = 1'b1; aeoi_rotate = 1'b1; irq_req = 8'h02;
        tick();
        pulse_inta();
        n_vec++; if (isr !== 8'h02) begin n_err++; $display("FAIL aeoi_set got=%h exp=02", isr); end
        irq_req = 8'h00;
        pulse_inta();
        n_vec++; if (isr !== 8'h00 || lowest_prio !== 3'd1 || vec_data !== 8'h41) begin
            n_err++; $display("FAIL aeoi_clr got isr=%h lp=%0d vd=%h exp 00/1/41", isr, lowest_prio, vec_data);
        end
        aeoi_en = 1'b0; aeoi_rotate = 1'b0;
        $display("aeoi: isr=%h lowest=%0d", isr, lowest_prio);
    endtask

    task automatic test_timeout();
        int seen = 0;
        irq_req = 8'h20;
        tick();
        pulse_inta();
        irq_req = 8'h00;
        n_vec++; if (isr !== 8'h20) begin n_err++; $display("FAIL tmo_set got=%h exp=20", isr); end
        for (int c = 1; c <= 20 && seen == 0; c++) begin
            tick();
            if (ack_abort === 1'b1) seen = c;
        end
        n_vec++; if (seen != 16) begin n_err++; $display("FAIL tmo_cycle got=%0d exp=16", seen); end
        n_vec++; if (isr !== 8'h00) begin n_err++; $display("FAIL tmo_isr got=%h exp=00", isr); end
        tick();
        n_vec++; if (ack_abort !== 1'b0) begin n_err++; $display("FAIL tmo_pulse got=%b exp=0", ack_abort); end
        $display("timeout: abort after %0d cycles", seen);
    endtask

    task automatic test_async_reset();
        irq_req = 8'h20;
        tick();
        pulse_inta();
        irq_req = 8'h00;
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (isr !== 8'h00 || lowest_prio !== 3'd7 || vec_data !== 8'h00 || int_out !== 1'b0) begin
            n_err++; $display("FAIL async_rst got isr=%h lp=%0d vd=%h int=%b exp 00/7/00/0", isr, lowest_prio, vec_data, int_out);
        end
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        pulse_inta();
        tick();
        n_vec++; if (ack_abort !== 1'b0 || vec_valid !== 1'b0) begin
            n_err++; $display("FAIL async_idle got ab=%b vv=%b exp 0/0", ack_abort, vec_valid);
        end
        pulse_inta();
        n_vec++; if (vec_data !== 8'h47) begin n_err++; $display("FAIL async_spur got=%h exp=47", vec_data); end
        $display("async reset: isr=%h", isr);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            bit slow = ((c / 250) % 2) == 1;
            irq_req = irq_req & ~m_irr_clear;
            if ($urandom_range(0, 3) == 0) irq_req[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 15) == 0) irq_req = 8'h00;
            imr = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
            inta_strobe = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
            eoi_valid = ($urandom_range(0, 5) == 0);
            eoi_specific = 1'($urandom);
            eoi_rotate = 1'($urandom);
            eoi_level = 3'($urandom);
            if (c % 50 == 0) begin aeoi_en = 1'($urandom); aeoi_rotate = 1'($urandom); end
            vector_base = 5'($urandom);
            tick();
            n_vec++; if (int_out !== m_int) begin n_err++; $display("FAIL rnd_int c=%0d got=%b exp=%b", c, int_out, m_int); end
            n_vec++; if (irr_clear !== m_irr_clear) begin n_err++; $display("FAIL rnd_irrc c=%0d got=%h exp=%h", c, irr_clear, m_irr_clear); end
            n_vec++; if (isr !== m_isr) begin n_err++; $display("FAIL rnd_isr c=%0d got=%h exp=%h", c, isr, m_isr); end
            n_vec++; if (lowest_prio !== 3'(m_lowest)) begin n_err++; $display("FAIL rnd_lowest c=%0d got=%0d exp=%0d", c, lowest_prio, m_lowest); end
            n_vec++; if (vec_valid !== m_vec_valid || (m_vec_valid && vec_data !== m_vec_data)) begin
                n_err++; $display("FAIL rnd_vec c=%0d got vv=%b vd=%h exp vv=%b vd=%h", c, vec_valid, vec_data, m_vec_valid, m_vec_data);
            end
            n_vec++; if (ack_abort !== m_abort) begin n_err++; $display("FAIL rnd_abort c=%0d got=%b exp=%b", c, ack_abort, m_abort); end
            if (m_vec_valid) $display("rnd c=%0d vector %h isr=%h", c, m_vec_data, m_isr);
            if (m_abort) $display("rnd c=%0d acknowledge aborted", c);
        end
        inta_strobe = 1'b0; eoi_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_nesting();
        test_rotation();
        test_spurious();
        test_aeoi();
        test_timeout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
